// File: rtl/r_dec_pkg.sv
// Shared constants and helpers for the r_dec integrate-and-dump decimator.
package r_dec_pkg;

    // Default input sample width
    localparam int WIN_DEFAULT = 19;

    // Output selection: keep the last sample of a frame, or dump the frame sum
    localparam bit MODE_HOLD = 1'b0;
    localparam bit MODE_DUMP = 1'b1;

    // Counter width for a modulo-n count; never narrower than one bit so that
    // n=1 still yields a legal vector
    function automatic int clog2(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/r_dec_phase.sv
// Modulo-R frame position counter for r_dec, with phase realignment on sync.
module r_dec_phase
    import r_dec_pkg::*;
#(
    parameter int R  = 2000,
    parameter int PW = clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          val_in,
    input  logic          sync,
    output logic [PW-1:0] phase,
    output logic          last
);

    // Explicit end-of-frame compare, so R need not be a power of two
    localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);
    // Position after a sample taken on sync; with R=1 that sample closes the frame
    localparam logic [PW-1:0] SYNC_NEXT  = (R == 1) ? '0 : PW'(1);

    logic [PW-1:0] phase_reg;

    assign phase = phase_reg;
    assign last  = val_in && !sync && (phase_reg == LAST_PHASE);

    // Advance on each accepted sample, wrap at R-1, realign on sync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_reg <= '0;
        end else if (sync) begin
            phase_reg <= val_in ? SYNC_NEXT : '0;
        end else if (val_in) begin
            phase_reg <= (phase_reg == LAST_PHASE) ? '0 : phase_reg + PW'(1);
        end
    end

endmodule

// File: rtl/r_dec.sv
// Integrate-and-dump rate decimator: one output per R accepted input samples,
// either the frame sum (MODE_DUMP) or the last sample of the frame (MODE_HOLD).
module r_dec
    import r_dec_pkg::*;
#(
    parameter int Win  = WIN_DEFAULT,
    parameter int R    = 2000,
    parameter int Wout = Win + $clog2(R),
    parameter bit MODE = MODE_DUMP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   val_in,
    input  logic signed [Win-1:0]  data_in,
    input  logic                   sync,
    output logic                   val_out,
    output logic signed [Wout-1:0] data_out,
    output logic [clog2(R)-1:0]    phase
);

    localparam int PW     = clog2(R);
    localparam bit SINGLE = (R == 1);

    logic signed [Wout-1:0] ext;
    logic signed [Wout-1:0] sum;
    logic signed [Wout-1:0] frame_sum;
    logic signed [Wout-1:0] acc_reg;
    logic signed [Wout-1:0] data_out_reg;
    logic                   val_out_reg;
    logic                   last;
    logic                   phase_zero;

    r_dec_phase #(
        .R  (R),
        .PW (PW)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .val_in (val_in),
        .sync   (sync),
        .phase  (phase),
        .last   (last)
    );

    // Sign-extend before any arithmetic; the sum wraps at Wout bits
    assign ext        = Wout'(data_in);
    assign sum        = acc_reg + ext;
    assign phase_zero = (phase == '0);
    // Sample 0 of a frame restarts the sum instead of adding to stale state
    assign frame_sum  = phase_zero ? ext : sum;

    assign val_out  = val_out_reg;
    assign data_out = data_out_reg;

    // Accumulate accepted samples and dump the frame result on its last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            data_out_reg <= '0;
            val_out_reg  <= 1'b0;
        end else begin
            val_out_reg <= 1'b0;
            if (sync) begin
                // Partial frame discarded; a coincident sample starts the new one
                acc_reg <= val_in ? ext : '0;
                if (SINGLE && val_in) begin
                    data_out_reg <= ext;
                    val_out_reg  <= 1'b1;
                end
            end else if (val_in) begin
                acc_reg <= frame_sum;
                if (last) begin
                    data_out_reg <= (MODE == MODE_DUMP) ? frame_sum : ext;
                    val_out_reg  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r_dec.sv
// Directed bench for r_dec: R=4 in both modes plus an R=1 instance, all fed
// the same stimulus; each scenario task checks the instances it is about.
module tb_r_dec;
    import r_dec_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                val_in;
    logic signed [18:0]  data_in;
    logic                sync;

    logic                vo_d, vo_h, vo_1;
    logic signed [20:0]  do_d, do_h;
    logic signed [18:0]  do_1;
    logic [1:0]          ph_d, ph_h;
    logic [0:0]          ph_1;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    r_dec #(.Win(19), .R(4), .MODE(MODE_DUMP)) u_dump (
        .clk(clk), .rst(rst), .val_in(val_in), .data_in(data_in), .sync(sync),
        .val_out(vo_d), .data_out(do_d), .phase(ph_d)
    );

    r_dec #(.Win(19), .R(4), .MODE(MODE_HOLD)) u_hold (
        .clk(clk), .rst(rst), .val_in(val_in), .data_in(data_in), .sync(sync),
        .val_out(vo_h), .data_out(do_h), .phase(ph_h)
    );

    r_dec #(.Win(19), .R(1), .MODE(MODE_DUMP)) u_one (
        .clk(clk), .rst(rst), .val_in(val_in), .data_in(data_in), .sync(sync),
        .val_out(vo_1), .data_out(do_1), .phase(ph_1)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; val_in = 1'b0; sync = 1'b0; data_in = '0;
        #1;
        vec_count++;
        if (vo_d !== 1'b0 || do_d !== 21'sd0 || ph_d !== 2'd0) begin
            err_count++;
            $display("FAIL reset_dump: vo=%b do=%0d ph=%0d, want 0 0 0", vo_d, do_d, ph_d);
        end
        vec_count++;
        if (vo_h !== 1'b0 || do_h !== 21'sd0 || ph_h !== 2'd0) begin
            err_count++;
            $display("FAIL reset_hold: vo=%b do=%0d ph=%0d, want 0 0 0", vo_h, do_h, ph_h);
        end
        vec_count++;
        if (vo_1 !== 1'b0 || do_1 !== 19'sd0 || ph_1 !== 1'b0) begin
            err_count++;
            $display("FAIL reset_r1: vo=%b do=%0d ph=%0d, want 0 0 0", vo_1, do_1, ph_1);
        end
        tick();
        tick();
        rst = 1'b0;
        $display("reset released");
    endtask

    // Inputs 1..8 back to back; strobes after samples 4 and 8
    task automatic test_back_to_back();
        int exp_ph[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};
        bit exp_vo[8]  = '{0, 0, 0, 1, 0, 0, 0, 1};
        int exp_dd[8]  = '{0, 0, 0, 10, 10, 10, 10, 26};
        int exp_dh[8]  = '{0, 0, 0, 4, 4, 4, 4, 8};
        for (int i = 0; i < 8; i++) begin
            val_in = 1'b1; data_in = 19'(i + 1);
            tick();
            $display("b2b sample %0d: vo_d=%b do_d=%0d do_h=%0d ph=%0d", i + 1, vo_d, do_d, do_h, ph_d);
            vec_count++;
            if (ph_d !== 2'(exp_ph[i]) || vo_d !== exp_vo[i] || do_d !== 21'(exp_dd[i])) begin
                err_count++;
                $display("FAIL b2b_dump[%0d]: ph=%0d vo=%b do=%0d, want %0d %b %0d",
                         i, ph_d, vo_d, do_d, exp_ph[i], exp_vo[i], exp_dd[i]);
            end
            vec_count++;
            if (vo_h !== exp_vo[i] || do_h !== 21'(exp_dh[i])) begin
                err_count++;
                $display("FAIL b2b_hold[%0d]: vo=%b do=%0d, want %b %0d",
                         i, vo_h, do_h, exp_vo[i], exp_dh[i]);
            end
        end
        val_in = 1'b0;
        tick();
        vec_count++;
        if (vo_d !== 1'b0 || do_d !== 21'sd26 || vo_h !== 1'b0 || do_h !== 21'sd8 || ph_d !== 2'd0) begin
            err_count++;
            $display("FAIL b2b_idle_hold: vo_d=%b do_d=%0d vo_h=%b do_h=%0d ph=%0d, want 0 26 0 8 0",
                     vo_d, do_d, vo_h, do_h, ph_d);
        end
    endtask

    // Four min-valued samples spaced three cycles apart: full-growth sum
    task automatic test_sparse_min();
        logic signed [20:0] want_d;
        logic signed [20:0] want_h;
        want_d = -21'sd1048576;
        want_h = -21'sd262144;
        for (int i = 0; i < 4; i++) begin
            val_in = 1'b1; data_in = -19'sd262144;
            tick();
            val_in = 1'b0;
            $display("sparse sample %0d: vo_d=%b do_d=%0d", i + 1, vo_d, do_d);
            vec_count++;
            if (vo_d !== (i == 3)) begin
                err_count++;
                $display("FAIL sparse_strobe[%0d]: vo=%b, want %b", i, vo_d, (i == 3));
            end
            tick();
            vec_count++;
            if (vo_d !== 1'b0) begin
                err_count++;
                $display("FAIL sparse_width[%0d]: vo=%b, want 0", i, vo_d);
            end
            tick();
        end
        vec_count++;
        if (do_d !== want_d || do_h !== want_h) begin
            err_count++;
            $display("FAIL sparse_value: do_d=%0d do_h=%0d, want %0d %0d", do_d, do_h, want_d, want_h);
        end
    endtask

    // sync with the 3rd sample drops the frame; also sync on the boundary wins
    task automatic test_sync();
        int  din[6]    = '{5, 5, 7, 1, 1, 1};
        bit  syn[6]    = '{0, 0, 1, 0, 0, 0};
        int  exp_ph[6] = '{1, 2, 1, 2, 3, 0};
        for (int i = 0; i < 6; i++) begin
            val_in = 1'b1; data_in = 19'(din[i]); sync = syn[i];
            tick();
            $display("sync sample %0d (sync=%b): vo_d=%b do_d=%0d ph=%0d", din[i], syn[i], vo_d, do_d, ph_d);
            vec_count++;
            if (ph_d !== 2'(exp_ph[i]) || vo_d !== (i == 5)) begin
                err_count++;
                $display("FAIL sync_seq[%0d]: ph=%0d vo=%b, want %0d %b", i, ph_d, vo_d, exp_ph[i], (i == 5));
            end
        end
        sync = 1'b0;
        vec_count++;
        if (do_d !== 21'sd10 || do_h !== 21'sd1) begin
            err_count++;
            $display("FAIL sync_value: do_d=%0d do_h=%0d, want 10 1", do_d, do_h);
        end
        // Boundary: 4th sample carries sync -> not emitted, new frame at phase 1
        for (int i = 0; i < 4; i++) begin
            val_in = 1'b1; data_in = 19'sd2; sync = (i == 3);
            tick();
        end
        vec_count++;
        if (vo_d !== 1'b0 || ph_d !== 2'd1 || do_d !== 21'sd10) begin
            err_count++;
            $display("FAIL sync_boundary: vo=%b ph=%0d do=%0d, want 0 1 10", vo_d, ph_d, do_d);
        end
        // Idle sync returns to frame start
        val_in = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        vec_count++;
        if (ph_d !== 2'd0 || vo_d !== 1'b0) begin
            err_count++;
            $display("FAIL sync_idle: ph=%0d vo=%b, want 0 0", ph_d, vo_d);
        end
    endtask

    // Asynchronous reset mid-frame, then a fresh frame of 3s
    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            val_in = 1'b1; data_in = 19'sd3;
            tick();
        end
        val_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        vec_count++;
        if (ph_d !== 2'd0 || vo_d !== 1'b0 || do_d !== 21'sd0 || do_h !== 21'sd0) begin
            err_count++;
            $display("FAIL async_reset: ph=%0d vo=%b do_d=%0d do_h=%0d, want 0 0 0 0", ph_d, vo_d, do_d, do_h);
        end
        #2 rst = 1'b0;
        $display("async reset applied mid-frame");
        for (int i = 0; i < 4; i++) begin
            val_in = 1'b1; data_in = 19'sd3;
            tick();
        end
        val_in = 1'b0;
        vec_count++;
        if (vo_d !== 1'b1 || do_d !== 21'sd12 || vo_h !== 1'b1 || do_h !== 21'sd3) begin
            err_count++;
            $display("FAIL post_reset_frame: vo_d=%b do_d=%0d vo_h=%b do_h=%0d, want 1 12 1 3",
                     vo_d, do_d, vo_h, do_h);
        end
    endtask

    // R=1: every sample is a frame
    task automatic test_r1();
        int din[2] = '{-5, 7};
        tick();
        for (int i = 0; i < 2; i++) begin
            val_in = 1'b1; data_in = 19'(din[i]);
            tick();
            $display("r1 sample %0d: vo=%b do=%0d ph=%0d", din[i], vo_1, do_1, ph_1);
            vec_count++;
            if (vo_1 !== 1'b1 || do_1 !== 19'(din[i]) || ph_1 !== 1'b0) begin
                err_count++;
                $display("FAIL r1_sample[%0d]: vo=%b do=%0d ph=%0d, want 1 %0d 0", i, vo_1, do_1, ph_1, din[i]);
            end
        end
        val_in = 1'b0;
        tick();
        vec_count++;
        if (vo_1 !== 1'b0 || do_1 !== 19'sd7) begin
            err_count++;
            $display("FAIL r1_idle: vo=%b do=%0d, want 0 7", vo_1, do_1);
        end
        val_in = 1'b1; sync = 1'b1; data_in = 19'sd9;
        tick();
        val_in = 1'b0; sync = 1'b0;
        vec_count++;
        if (vo_1 !== 1'b1 || do_1 !== 19'sd9 || ph_1 !== 1'b0) begin
            err_count++;
            $display("FAIL r1_sync: vo=%b do=%0d ph=%0d, want 1 9 0", vo_1, do_1, ph_1);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sparse_min();
        test_sync();
        test_async_reset();
        test_r1();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/r_dec.md
Name: r_dec

Overview:
- Integrate-and-dump rate decimator. It is the counterpart of the R_INT rate-change stage: it takes samples at the high rate and emits one sample per R accepted inputs.
- Sits after the high-rate path and feeds the low-rate path. It uses the same val_in/val_out single-cycle valid-strobe convention as R_INT.
- MODE selects one of two outputs each frame:
  - the sum of the R inputs (integrate-and-dump), or
  - the last input of the frame (pure downsample).

Parameters:
- Win, 19, input sample width (signed two's complement).
- R, 2000, decimation factor. Legal range is R >= 1.
- Wout, Win+$clog2(R), output width. The default gives full growth, so the output never overflows.
- MODE, 1, selects 1 = integrate-and-dump or 0 = keep-last-sample.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- val_in  input  1  data_in is valid this cycle; the sample is accepted on this edge.
- data_in  input  Win  signed input sample.
- sync  input  1  phase realign strobe; starts a new frame.
- val_out  output  1  one-cycle strobe marking data_out as new.
- data_out  output  Wout  signed decimated sample; holds its value between strobes.
- phase  output  $clog2(R) (min 1)  current frame position, 0..R-1. Debug/monitor port.

Behaviour:
- Reset (asynchronous, rst=1):
  - phase=0, accumulator=0, data_out=0, val_out=0.
  - Takes effect immediately, mid-frame included; the partial frame is discarded.
  - After release, the next accepted sample is sample 0 of a new frame.
- Input extension: data_in is sign-extended to Wout before any arithmetic.
- Accept (val_in=1, sync=0):
  - If phase==0: acc <= ext(data_in).
  - Otherwise: acc <= acc + ext(data_in).
  - If phase==R-1:
    - MODE=1: data_out <= acc + ext(data_in).
    - MODE=0: data_out <= ext(data_in).
    - In both modes: val_out <= 1 and phase <= 0.
  - Otherwise phase <= phase + 1.
- Idle (val_in=0): phase, acc and data_out hold; val_out=0.
- Latency: val_out rises on the clock edge that accepts the R-th sample, so it is visible the cycle after that sample. The strobe is exactly one cycle wide.
- Back-to-back: with val_in held high, val_out pulses every R cycles.
- R=1:
  - Every accepted sample produces val_out on the next cycle, with data_out = ext(data_in) in both modes.
  - phase stays 0.
- sync=1:
  - The current partial frame is discarded; phase and acc return to frame start. No val_out is produced for the discarded frame.
  - If val_in=1 in the same cycle, that sample is taken as sample 0 of the new frame: acc <= ext(data_in), phase <= 1. With R=1 the sample completes a frame and emits it.
  - If val_in=0: acc <= 0 and phase <= 0.
- sync on the R-1 boundary cycle: sync wins. The frame is discarded and not emitted.
- Arithmetic:
  - Wrap-around two's complement at Wout bits; no saturation.
  - With the default Wout, R*(-2^(Win-1)) fits exactly.
- Phase counter wrap: compare against R-1 explicitly, so R need not be a power of two.

Decomposition:
- Shared package r_dec_pkg:
  - a constant function clog2 guarding the R=1 case, returning 1 in that case;
  - the MODE encodings MODE_HOLD=0 and MODE_DUMP=1;
  - a default width constant for Win.
- One sub-module r_dec_phase holds the modulo-R phase counter. It has clk, rst, val_in and sync inputs, and phase and last (phase==R-1 & val_in & !sync) outputs.
- The accumulator and output register live in the top-level module.

Test Plan:
- R=4, MODE=1, val_in high continuously, inputs 1,2,3,4,5,6,7,8 -> val_out pulses one cycle after samples 4 and 8. data_out = 10, then 26; phase sequence is 0,1,2,3,0,...
- R=4, MODE=0, same stimulus -> data_out = 4, then 8. The same values hold through the gaps between strobes.
- R=4, MODE=1, val_in=1 once every 3 cycles, inputs -262144 (min 19-bit) four times -> single strobe with data_out = -1048576. There is no overflow in the 21-bit output.
- R=4, MODE=1, sync raised together with the 3rd valid sample (inputs 5,5,7) then 1,1,1 -> first frame is dropped. Next strobe is after the 1,1,1 samples, with data_out = 7+1+1+1 = 10.
- R=4, rst asserted asynchronously mid-frame after 2 samples -> all outputs are 0 immediately. The next 4 samples of value 3 give data_out = 12.
- R=1, MODE=1, inputs -5, 7 on consecutive cycles -> val_out high for two consecutive cycles, data_out = -5 then 7.
